tlb_lookup_arbiter: RTL
=======================

# tlb_lookup_arbiter

Shares the single TLB search port between three requesters: data-side MMU (load/store translation), instruction-side MMU (fetch translation) and CP0 (TLBP probe). Requests are granted in the cycle they are seen, the TLB is searched from a registered copy one cycle later, and the result is returned on a shared response bus tagged with a per-requester valid. Sits between the IF/MEM MMUs plus CP0 and the TLB array. Sustains one lookup per cycle.

## Interface
- TLB_IDX_W, 4: width of TLB index (16 entries).
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- d_req_i / i_req_i / p_req_i  in  1 each  lookup request: data, inst, probe.
- d_vpn2_i / i_vpn2_i / p_vpn2_i  in  19 each  VA[31:13].
- d_odd_i / i_odd_i / p_odd_i  in  1 each  VA[12].
- d_asid_i / i_asid_i / p_asid_i  in  8 each  ASID.
- d_gnt_o / i_gnt_o / p_gnt_o  out  1 each  request accepted this cycle (combinational).
- tlb_wr_i  in  1  CP0 is writing the TLB (TLBWI/TLBWR) this cycle.
- tlb_vpn2_o, tlb_odd_o, tlb_asid_o  out  19/1/8  search key to TLB.
- tlb_hit_i, tlb_index_i[TLB_IDX_W], tlb_pfn_i[20], tlb_c_i[3], tlb_d_i, tlb_v_i  in  combinational TLB result.
- d_resp_valid_o / i_resp_valid_o / p_resp_valid_o  out  1 each  one-cycle result strobe.
- resp_hit_o, resp_index_o, resp_pfn_o, resp_c_o, resp_d_o, resp_v_o  out  shared registered result.

## Operation
- Stage G (grant): winner chosen among asserted reqs; at most one gnt high. Fixed priority p > d > i. Grant only if tlb_wr_i low and stage S can accept.
- Stage S (search): s_valid, s_id[1:0], s_vpn2, s_odd, s_asid registered from winner. tlb_*_o driven from S regs (zero when !s_valid).
- Stage R (response): on S valid and tlb_wr_i low, TLB outputs captured into resp regs; matching *_resp_valid_o high next cycle, others low.
- tlb_wr_i high while s_valid: S lookup is not captured, S regs hold (replayed next cycle), no new grant. Prevents returning results from a TLB being rewritten.
- Requester protocol: hold req and key stable until gnt; may drop req without gnt (cancel, no side effect). After gnt, a requester may re-request the next cycle.
- Miss returned as hit=0; other fields unspecified and must be ignored by requester. Exception decoding is not done here.

## Timing
- Reset (async assert, sync release): s_valid=0, s_id=0, keys=0, all *_resp_valid_o=0, resp_* =0, RR pointer=data.
- gnt at cycle T; TLB key at T+1; resp_valid at T+2. Each tlb_wr_i cycle overlapping S adds one cycle.
- Back-to-back: grants in T, T+1, T+2 give responses T+2, T+3, T+4.
- tlb_wr_i at cycle T with S empty: no grant in T; grants resume T+1.
- Reset mid-operation: in-flight lookup dropped, no response emitted.

## Configuration
- TLB_ARB_RR_EN defined: d and i arbitrate round-robin (pointer flips to the other after a grant to one when both request); p still strictly highest. Without it: fixed p > d > i, inst may starve under continuous data requests.

## Test plan
- Single i_req, vpn2=0x00400, asid=0x01, TLB hit pfn=0x1F000 c=3 -> i_gnt at T, tlb_vpn2_o=0x00400 at T+1, i_resp_valid at T+2 with pfn=0x1F000, hit=1.
- d_req and i_req together for 4 cycles -> without macro: d granted 4 times, i none; with TLB_ARB_RR_EN: d,i,d,i.
- p_req with d_req and i_req -> p granted first; p_resp_valid only, hit and index=5 returned for probe.
- tlb_wr_i pulsed at T+1 after d grant -> no response at T+2; key held; d_resp_valid at T+3 reflecting post-write TLB; no grant at T+1.
- rst asserted at T+1 after grant -> all valids 0 immediately; no response after release.
- TLB miss (hit=0) for data vpn2=0x7FFFF -> d_resp_valid at T+2 with resp_hit_o=0.

Source files
------------

// File: rtl/tlb_lookup_arbiter_if.sv
// tlb_lookup_arbiter_if
// Bundles everything that crosses the arbiter boundary: the three requester
// ports (data MMU, instruction MMU, CP0 probe) and the TLB search/result port.
//
// Valid/ready semantics, one rule for all three requesters: a lookup transfers
// in the cycle where *_req_i and *_gnt_o are both high. Until then the
// requester holds *_req_i and its key stable. It may drop *_req_i before a
// grant with no side effect. The result comes back later as a one-cycle
// *_resp_valid_o strobe, and the arbiter never stalls that strobe.
//
// Modports:
//   slave  - the arbiter's view (drives grants, TLB key and responses)
//   master - the environment's view (requesters, CP0 write strobe, TLB array)
interface tlb_lookup_arbiter_if #(
  parameter int TLB_IDX_W = 4
);
  // requesters
  logic                 d_req_i, i_req_i, p_req_i;
  logic [18:0]          d_vpn2_i, i_vpn2_i, p_vpn2_i;
  logic                 d_odd_i, i_odd_i, p_odd_i;
  logic [7:0]           d_asid_i, i_asid_i, p_asid_i;
  logic                 d_gnt_o, i_gnt_o, p_gnt_o;
  // CP0 write in progress
  logic                 tlb_wr_i;
  // TLB search key and combinational result
  logic [18:0]          tlb_vpn2_o;
  logic                 tlb_odd_o;
  logic [7:0]           tlb_asid_o;
  logic                 tlb_hit_i;
  logic [TLB_IDX_W-1:0] tlb_index_i;
  logic [19:0]          tlb_pfn_i;
  logic [2:0]           tlb_c_i;
  logic                 tlb_d_i, tlb_v_i;
  // registered response
  logic                 d_resp_valid_o, i_resp_valid_o, p_resp_valid_o;
  logic                 resp_hit_o;
  logic [TLB_IDX_W-1:0] resp_index_o;
  logic [19:0]          resp_pfn_o;
  logic [2:0]           resp_c_o;
  logic                 resp_d_o, resp_v_o;

  modport slave (
    input  d_req_i, i_req_i, p_req_i,
    input  d_vpn2_i, i_vpn2_i, p_vpn2_i,
    input  d_odd_i, i_odd_i, p_odd_i,
    input  d_asid_i, i_asid_i, p_asid_i,
    output d_gnt_o, i_gnt_o, p_gnt_o,
    input  tlb_wr_i,
    output tlb_vpn2_o, tlb_odd_o, tlb_asid_o,
    input  tlb_hit_i, tlb_index_i, tlb_pfn_i, tlb_c_i, tlb_d_i, tlb_v_i,
    output d_resp_valid_o, i_resp_valid_o, p_resp_valid_o,
    output resp_hit_o, resp_index_o, resp_pfn_o, resp_c_o, resp_d_o, resp_v_o
  );

  modport master (
    output d_req_i, i_req_i, p_req_i,
    output d_vpn2_i, i_vpn2_i, p_vpn2_i,
    output d_odd_i, i_odd_i, p_odd_i,
    output d_asid_i, i_asid_i, p_asid_i,
    input  d_gnt_o, i_gnt_o, p_gnt_o,
    output tlb_wr_i,
    input  tlb_vpn2_o, tlb_odd_o, tlb_asid_o,
    output tlb_hit_i, tlb_index_i, tlb_pfn_i, tlb_c_i, tlb_d_i, tlb_v_i,
    input  d_resp_valid_o, i_resp_valid_o, p_resp_valid_o,
    input  resp_hit_o, resp_index_o, resp_pfn_o, resp_c_o, resp_d_o, resp_v_o
  );
endinterface

// File: rtl/tlb_lookup_arbiter.sv
// tlb_lookup_arbiter
// Shares one TLB search port among the data MMU, the instruction MMU and the
// CP0 probe. The pipeline has three stages:
//   G - combinational grant to at most one requester
//   S - registered search key, presented to the TLB
//   R - registered TLB result plus a per-requester valid strobe
// The pipeline sustains one lookup per cycle. The grant-to-response latency is
// 2 cycles, plus one cycle for each tlb_wr_i cycle that overlaps stage S.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - tlb_lookup_arbiter_if.slave (requesters, TLB port, responses)
//
// Build option TLB_ARB_RR_EN: data and inst alternate when both request.
// The probe always keeps strict top priority. Without this option the
// priority is fixed at probe > data > inst.
module tlb_lookup_arbiter #(
  parameter int TLB_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  tlb_lookup_arbiter_if.slave  bus
);

  localparam logic [1:0] ID_D = 2'd0;
  localparam logic [1:0] ID_I = 2'd1;
  localparam logic [1:0] ID_P = 2'd2;

  logic                 gnt_d, gnt_i, gnt_p;
  logic [1:0]           win_id;
  logic [18:0]          win_vpn2;
  logic                 win_odd;
  logic [7:0]           win_asid;

  logic                 s_valid;
  logic [1:0]           s_id;
  logic [18:0]          s_vpn2;
  logic                 s_odd;
  logic [7:0]           s_asid;

  logic [2:0]           resp_valid;   // {probe, inst, data}
  logic                 resp_hit;
  logic [TLB_IDX_W-1:0] resp_index;
  logic [19:0]          resp_pfn;
  logic [2:0]           resp_c;
  logic                 resp_d, resp_v;

  // Stage R never back-pressures, so S always drains unless a TLB write
  // freezes it. S can therefore accept a new lookup exactly when no write
  // is in progress.
  logic                 advance;
  assign advance = !bus.tlb_wr_i;

`ifdef TLB_ARB_RR_EN
  logic rr_inst;   // 1: inst wins the next data/inst tie
  logic both_di;
  assign both_di = bus.d_req_i && bus.i_req_i;
`endif

  // Stage G: grant
  always_comb begin
    gnt_d = 1'b0;
    gnt_i = 1'b0;
    gnt_p = 1'b0;
    if (advance) begin
      if (bus.p_req_i) begin
        gnt_p = 1'b1;
`ifdef TLB_ARB_RR_EN
      end else if (both_di) begin
        gnt_i = rr_inst;
        gnt_d = !rr_inst;
`endif
      end else if (bus.d_req_i) begin
        gnt_d = 1'b1;
      end else if (bus.i_req_i) begin
        gnt_i = 1'b1;
      end
    end
  end

  // The winner's key. It is all zero when nothing is granted, so an empty
  // S stage also presents a zero key.
  always_comb begin
    win_id   = ID_D;
    win_vpn2 = '0;
    win_odd  = 1'b0;
    win_asid = '0;
    if (gnt_p) begin
      win_id   = ID_P;
      win_vpn2 = bus.p_vpn2_i;
      win_odd  = bus.p_odd_i;
      win_asid = bus.p_asid_i;
    end else if (gnt_d) begin
      win_id   = ID_D;
      win_vpn2 = bus.d_vpn2_i;
      win_odd  = bus.d_odd_i;
      win_asid = bus.d_asid_i;
    end else if (gnt_i) begin
      win_id   = ID_I;
      win_vpn2 = bus.i_vpn2_i;
      win_odd  = bus.i_odd_i;
      win_asid = bus.i_asid_i;
    end
  end

  assign bus.d_gnt_o = gnt_d;
  assign bus.i_gnt_o = gnt_i;
  assign bus.p_gnt_o = gnt_p;

  // Stage S: holds its contents during a TLB write, which replays the lookup
  // against the updated array in the following cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_valid <= 1'b0;
      s_id    <= ID_D;
      s_vpn2  <= '0;
      s_odd   <= 1'b0;
      s_asid  <= '0;
    end else if (advance) begin
      s_valid <= gnt_d || gnt_i || gnt_p;
      s_id    <= win_id;
      s_vpn2  <= win_vpn2;
      s_odd   <= win_odd;
      s_asid  <= win_asid;
    end
  end

  assign bus.tlb_vpn2_o = s_valid ? s_vpn2 : '0;
  assign bus.tlb_odd_o  = s_valid ? s_odd  : 1'b0;
  assign bus.tlb_asid_o = s_valid ? s_asid : '0;

  // Stage R: capture only when the TLB is stable (no write this cycle).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= '0;
      resp_hit   <= 1'b0;
      resp_index <= '0;
      resp_pfn   <= '0;
      resp_c     <= '0;
      resp_d     <= 1'b0;
      resp_v     <= 1'b0;
    end else begin
      resp_valid <= '0;
      if (s_valid && advance) begin
        resp_valid <= {s_id == ID_P, s_id == ID_I, s_id == ID_D};
        resp_hit   <= bus.tlb_hit_i;
        resp_index <= bus.tlb_index_i;
        resp_pfn   <= bus.tlb_pfn_i;
        resp_c     <= bus.tlb_c_i;
        resp_d     <= bus.tlb_d_i;
        resp_v     <= bus.tlb_v_i;
      end
    end
  end

  assign bus.d_resp_valid_o = resp_valid[0];
  assign bus.i_resp_valid_o = resp_valid[1];
  assign bus.p_resp_valid_o = resp_valid[2];
  assign bus.resp_hit_o     = resp_hit;
  assign bus.resp_index_o   = resp_index;
  assign bus.resp_pfn_o     = resp_pfn;
  assign bus.resp_c_o       = resp_c;
  assign bus.resp_d_o       = resp_d;
  assign bus.resp_v_o       = resp_v;

`ifdef TLB_ARB_RR_EN
  // Hand the next tie to whichever of data/inst lost this one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_inst <= 1'b0;
    end else if (both_di && (gnt_d || gnt_i)) begin
      rr_inst <= gnt_d;
    end
  end
`endif

endmodule
